// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory responder slice.
//   WORD_W / MASK_W     : data word width and byte-lane count
//   state_e             : responder FSM encoding (IDLE, WAIT, RESP)
//   WE_WRITE / WE_READ  : values of the we_re request bit
//   merge_bytes()       : byte-lane merge of new data into an old word
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int MASK_W = 4;

  localparam logic WE_WRITE = 1'b1;
  localparam logic WE_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Lanes with mask bit set take the new byte, the others keep the old one.
  function automatic logic [WORD_W-1:0] merge_bytes(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic [MASK_W-1:0] lane_mask
  );
    logic [WORD_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MASK_W; i++) begin
      if (lane_mask[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH_WORDS x 32-bit storage.
//   clk_i     : clock, write port is synchronous
//   we_i      : write enable for the current edge
//   wmask_i   : byte-lane enables of the write
//   waddr_i   : write word index
//   wdata_i   : write data
//   raddr_i   : read word index
//   rdata_o   : asynchronous read data of mem[raddr_i]
// INIT_FILE is accepted for interface compatibility; contents are never
// cleared by reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = "",
  localparam int   AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [MASK_W-1:0] wmask_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= merge_bytes(mem_q[waddr_i], wdata_i, wmask_i);
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-port memory target with programmable latency.
//   clk        : clock
//   rst        : synchronous active-high reset (memory contents kept)
//   request    : held high by the requester to start a transaction
//   we_re      : 1 = write, 0 = read (sampled at acceptance)
//   mask       : byte-lane enables for writes (sampled at acceptance)
//   address    : byte address, word index = address[AW+1:2]
//   store_data : write data (sampled at acceptance)
//   load_data  : read data / pre-write word, valid only with valid=1
//   valid      : one-cycle completion pulse, LATENCY cycles after acceptance
//   busy       : high from acceptance through the valid cycle
module mem_responder
  import mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    LATENCY     = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request,
  input  logic              we_re,
  input  logic [MASK_W-1:0] mask,
  input  logic [31:0]       address,
  input  logic [WORD_W-1:0] store_data,
  output logic [WORD_W-1:0] load_data,
  output logic              valid,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [MASK_W-1:0] mask_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic              valid_q;
  logic              busy_q;
  logic [WORD_W-1:0] load_data_q;

  logic [AW-1:0]     addr_idx_s;
  logic [AW-1:0]     raddr_s;
  logic [WORD_W-1:0] rdata_s;
  logic              mem_we_s;
  logic              unused_addr_s;

  // Upper address bits alias (wrap) and the byte offset is ignored.
  assign addr_idx_s    = address[AW+1:2];
  assign unused_addr_s = ^{address[31:AW+2], address[1:0]};

  // With LATENCY=1 the word is fetched on the acceptance edge itself, so
  // the read port looks at the live address while idle.
  assign raddr_s = (state_q == IDLE) ? addr_idx_s : idx_q;

  // The write commits on the edge ending RESP; a reset on that edge
  // aborts it.
  assign mem_we_s = (state_q == RESP) && (we_q == WE_WRITE) && !rst;

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk_i  (clk),
    .we_i   (mem_we_s),
    .wmask_i(mask_q),
    .waddr_i(idx_q),
    .wdata_i(wdata_q),
    .raddr_i(raddr_s),
    .rdata_o(rdata_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      load_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q     <= 1'b0;
          load_data_q <= '0;
          if (request) begin
            we_q    <= we_re;
            mask_q  <= mask;
            idx_q   <= addr_idx_s;
            wdata_q <= store_data;
            busy_q  <= 1'b1;
            cnt_q   <= 4'(LATENCY - 1);
            if (LATENCY == 1) begin
              state_q     <= RESP;
              valid_q     <= 1'b1;
              load_data_q <= rdata_s;
            end else begin
              state_q <= WAIT;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          // Counter about to hit zero: the next cycle is the RESP cycle.
          if (cnt_q == 4'd1) begin
            state_q     <= RESP;
            valid_q     <= 1'b1;
            load_data_q <= rdata_s;
          end else begin
            state_q <= WAIT;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          valid_q     <= 1'b0;
          busy_q      <= 1'b0;
          load_data_q <= '0;
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= 4'd0;
          valid_q     <= 1'b0;
          busy_q      <= 1'b0;
          load_data_q <= '0;
        end
      endcase
    end
  end

  assign load_data = load_data_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule
